// File: rtl/dxm_int_servicer_if.sv
// Source-side and handler-side signals of the interrupt servicer.
// master = servicer view, slave = interrupt source / handler / bench view.
`timescale 1ns/1ps
interface dxm_int_servicer_if #(
  parameter int VEC_W = 8
);
  localparam int IDX_W = $clog2(VEC_W);

  logic             int_req;
  logic [VEC_W-1:0] status;
  logic [VEC_W-1:0] mask;
  logic             clr_status_1p;
  logic [VEC_W-1:0] clr_vec;
  logic             svc_valid;
  logic [IDX_W-1:0] svc_idx;
  logic             svc_ready;

  modport master (
    input  int_req, status, mask, svc_ready,
    output clr_status_1p, clr_vec, svc_valid, svc_idx
  );

  modport slave (
    output int_req, status, mask, svc_ready,
    input  clr_status_1p, clr_vec, svc_valid, svc_idx
  );
endinterface

// File: rtl/dxm_int_servicer.sv
// Services pending interrupt bits one per pass, lowest index first, then clears them at the source.
// Optional DISPATCH timeout is built only when DXM_INT_SVC_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module dxm_int_servicer #(
  parameter int VEC_W  = 8,
  parameter int TO_CYC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  dxm_int_servicer_if.master  bus,
  output logic                busy,
  output logic [7:0]          spur_cnt,
  output logic                svc_timeout
);
  localparam int IDX_W = $clog2(VEC_W);

  typedef enum logic [2:0] {
    IDLE, SAMPLE, DISPATCH, CLEAR, SETTLE1, SETTLE2
  } state_t;

  state_t           state;
  logic [VEC_W-1:0] pend;
  logic             pend_any;
  logic [IDX_W-1:0] low_idx;
  logic             svc_valid_q;
  logic             clr_q;
  logic [VEC_W-1:0] clr_vec_q;
  logic [IDX_W-1:0] idx_q;
  logic             busy_q;
  logic [7:0]       spur_q;
  logic             to_hit;

  assign pend     = bus.status & ~bus.mask;
  assign pend_any = |pend;

  always_comb begin
    low_idx = '0;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (pend[i]) low_idx = IDX_W'(i);
    end
  end

`ifdef DXM_INT_SVC_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       to_pulse;
  assign to_hit      = (to_cnt == 8'(TO_CYC - 1));
  assign svc_timeout = to_pulse;
`else
  assign to_hit      = 1'b0;
  // Constant 0 over the legal TO_CYC range (1..255).
  assign svc_timeout = (TO_CYC < 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      svc_valid_q <= 1'b0;
      clr_q       <= 1'b0;
      clr_vec_q   <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      spur_q      <= '0;
`ifdef DXM_INT_SVC_TIMEOUT_EN
      to_cnt      <= '0;
      to_pulse    <= 1'b0;
`endif
    end else begin
      clr_q     <= 1'b0;
      clr_vec_q <= '0;
`ifdef DXM_INT_SVC_TIMEOUT_EN
      to_pulse  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (enable && bus.int_req) begin
            state  <= SAMPLE;
            busy_q <= 1'b1;
          end
        end
        SAMPLE: begin
          if (pend_any) begin
            idx_q       <= low_idx;
            svc_valid_q <= 1'b1;
            state       <= DISPATCH;
`ifdef DXM_INT_SVC_TIMEOUT_EN
            to_cnt      <= '0;
`endif
          end else begin
            if (spur_q != 8'hFF) spur_q <= spur_q + 8'd1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        DISPATCH: begin
          // A handshake on the timeout edge wins: the bit counts as serviced.
          if (bus.svc_ready || to_hit) begin
            svc_valid_q <= 1'b0;
            clr_q       <= 1'b1;
            clr_vec_q   <= VEC_W'(1) << idx_q;
            state       <= CLEAR;
`ifdef DXM_INT_SVC_TIMEOUT_EN
            to_pulse    <= !bus.svc_ready;
          end else begin
            to_cnt      <= to_cnt + 8'd1;
`endif
          end
        end
        CLEAR:   state <= SETTLE1;
        SETTLE1: state <= SETTLE2;
        SETTLE2: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.svc_valid     = svc_valid_q;
  assign bus.svc_idx       = idx_q;
  assign bus.clr_status_1p = clr_q;
  assign bus.clr_vec       = clr_vec_q;
  assign busy              = busy_q;
  assign spur_cnt          = spur_q;
endmodule

// File: tb/tb_dxm_int_servicer.sv
// Bench for dxm_int_servicer: directed cases plus a randomized run against a modelled interrupt source.
`timescale 1ns/1ps
module tb_dxm_int_servicer;
  localparam int VEC_W  = 8;
  localparam int TO_CYC = 4;
`ifdef DXM_INT_SVC_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       busy;
  logic       svc_timeout;
  logic [7:0] spur_cnt;

  dxm_int_servicer_if #(.VEC_W(VEC_W)) bus ();

  dxm_int_servicer #(.VEC_W(VEC_W), .TO_CYC(TO_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .bus         (bus),
    .busy        (busy),
    .spur_cnt    (spur_cnt),
    .svc_timeout (svc_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic             use_src = 1'b0;
  logic             drv_req = 1'b0;
  logic             drv_ready = 1'b0;
  logic [VEC_W-1:0] drv_status = '0;
  logic [VEC_W-1:0] drv_mask = '0;
  logic [VEC_W-1:0] drv_events = '0;
  logic [VEC_W-1:0] src_status;
  logic             src_req;

  assign bus.int_req   = use_src ? src_req : drv_req;
  assign bus.status    = use_src ? src_status : drv_status;
  assign bus.mask      = drv_mask;
  assign bus.svc_ready = drv_ready;

  // Interrupt source: new events beat the clear; int_req trails status by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_status <= '0;
      src_req    <= 1'b0;
    end else begin
      src_status <= (src_status & ~(bus.clr_status_1p ? bus.clr_vec : '0)) | drv_events;
      src_req    <= |(src_status & ~drv_mask);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [VEC_W-1:0] v);
    for (int i = 0; i < VEC_W; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (bus.svc_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  // One full pass with svc_ready already high; exp_lat < 0 skips the latency check.
  task automatic run_pass(input string tag, input int exp_idx, input int exp_lat);
    int cyc;
    drv_ready = 1'b1;
    wait_valid(30, cyc);
    if (exp_lat >= 0) check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    else              check({tag, " valid seen"}, 32'(cyc > 0), 32'd1);
    check({tag, " idx"}, 32'(bus.svc_idx), 32'(exp_idx));
    tick();
    check({tag, " clr strobe"}, 32'(bus.clr_status_1p), 32'd1);
    check({tag, " clr_vec"}, 32'(bus.clr_vec), 32'd1 << exp_idx);
    check({tag, " valid drop"}, 32'(bus.svc_valid), 32'd0);
    drv_status = drv_status & ~(VEC_W'(1) << exp_idx);
    drv_req    = |(drv_status & ~drv_mask);
    tick();
    check({tag, " strobe 1 cycle"}, 32'({bus.clr_status_1p, bus.clr_vec}), 32'd0);
    check({tag, " busy settle1"}, 32'(busy), 32'd1);
    tick();
    check({tag, " busy settle2"}, 32'(busy), 32'd1);
    tick();
    check({tag, " idle after pass"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int cyc, hi, seen;
    logic [VEC_W-1:0] pend_pre;
    logic req_h0, req_h1, valid_prev, ready_pre, exp_clr, exp_to;
    int exp_idx, dcnt;

    #2;
    rst_n = 1'b0;
    tick(2);
    check("reset valid", 32'(bus.svc_valid), 32'd0);
    check("reset clr", 32'(bus.clr_status_1p), 32'd0);
    check("reset clr_vec", 32'(bus.clr_vec), 32'd0);
    check("reset idx", 32'(bus.svc_idx), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset spur", 32'(spur_cnt), 32'd0);
    check("reset timeout", 32'(svc_timeout), 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();

    // Single bit 2
    drv_status = 8'h04; drv_mask = 8'h00; drv_req = 1'b1;
    run_pass("single", 2, 2);
    check("single spur", 32'(spur_cnt), 32'd0);

    // Two bits, ascending order
    drv_status = 8'h28; drv_req = 1'b1;
    run_pass("multi first", 3, 2);
    run_pass("multi second", 5, -1);

    // Masked-only request is spurious
    drv_status = 8'h01; drv_mask = 8'h01; drv_req = 1'b1;
    tick();
    drv_req = 1'b0;
    check("spur busy in sample", 32'(busy), 32'd1);
    tick();
    check("spur count", 32'(spur_cnt), 32'd1);
    check("spur back idle", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= int'(bus.svc_valid);
    end
    check("spur no valid", 32'(seen), 32'd0);
    drv_mask = 8'h00; drv_status = 8'h00;

    // Handler stalls
    drv_status = 8'h02; drv_req = 1'b1; drv_ready = 1'b0;
    wait_valid(20, cyc);
    check("stall valid latency", 32'(cyc), 32'd2);
    drv_req = 1'b0;
    if (TIMEOUT_ON) begin
      for (int i = 0; i < TO_CYC - 1; i++) begin
        tick();
        check("to dispatch valid", 32'(bus.svc_valid), 32'd1);
        check("to no early pulse", 32'(svc_timeout), 32'd0);
      end
      tick();
      check("to pulse", 32'(svc_timeout), 32'd1);
      check("to clr strobe", 32'(bus.clr_status_1p), 32'd1);
      check("to clr_vec", 32'(bus.clr_vec), 32'h02);
      tick();
      check("to pulse 1 cycle", 32'(svc_timeout), 32'd0);
    end else begin
      hi = 0;
      for (int i = 0; i < 100; i++) begin
        tick();
        hi += int'(bus.svc_valid);
      end
      check("stall valid held", 32'(hi), 32'd100);
      check("stall no timeout", 32'(svc_timeout), 32'd0);
      drv_ready = 1'b1;
      tick();
      check("stall late clr", 32'(bus.clr_status_1p), 32'd1);
      check("stall late clr_vec", 32'(bus.clr_vec), 32'h02);
    end
    drv_status = 8'h00; drv_ready = 1'b0;
    tick(4);

    // Reset during DISPATCH
    drv_status = 8'h10; drv_req = 1'b1;
    wait_valid(20, cyc);
    check("rst dispatch reached", 32'(cyc), 32'd2);
    drv_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst valid", 32'(bus.svc_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst clr", 32'(bus.clr_status_1p), 32'd0);
    check("rst idx", 32'(bus.svc_idx), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= int'({bus.clr_status_1p, busy, bus.svc_valid});
    end
    check("rst no strobe after", 32'(seen), 32'd0);
    drv_status = 8'h00;

    // Spurious saturation
    pulse_reset();
    check("sat start", 32'(spur_cnt), 32'd0);
    drv_status = 8'h01; drv_mask = 8'h01; drv_req = 1'b1;
    tick(508);
    check("sat 254", 32'(spur_cnt), 32'd254);
    tick(92);
    check("sat 255", 32'(spur_cnt), 32'd255);
    drv_req = 1'b0; drv_status = 8'h00; drv_mask = 8'h00;
    tick(2);
    check("sat idle", 32'(busy), 32'd0);

    // Randomized run against the source model
    pulse_reset();
    use_src    = 1'b1;
    pend_pre   = src_status & ~drv_mask;
    req_h0     = enable & src_req;
    req_h1     = 1'b0;
    ready_pre  = drv_ready;
    valid_prev = 1'b0;
    exp_idx    = 0;
    dcnt       = 0;
    for (int k = 0; k < 3000; k++) begin
      bit drain;
      tick();
      exp_to  = TIMEOUT_ON && valid_prev && !ready_pre && (dcnt >= TO_CYC);
      exp_clr = valid_prev && (ready_pre || exp_to);
      check("rnd clr", 32'(bus.clr_status_1p), 32'(exp_clr));
      check("rnd clr_vec", 32'(bus.clr_vec), exp_clr ? (32'd1 << exp_idx) : 32'd0);
      check("rnd timeout", 32'(svc_timeout), 32'(exp_to));
      if (bus.svc_valid && !valid_prev) begin
        check("rnd req before valid", 32'(req_h1), 32'd1);
        check("rnd pend at sample", 32'(pend_pre != '0), 32'd1);
        exp_idx = lowest(pend_pre);
        check("rnd idx", 32'(bus.svc_idx), 32'(exp_idx));
      end else if (bus.svc_valid) begin
        check("rnd idx hold", 32'(bus.svc_idx), 32'(exp_idx));
      end
      dcnt       = bus.svc_valid ? (valid_prev ? dcnt + 1 : 1) : 0;
      valid_prev = bus.svc_valid;

      drain      = (k >= 2600);
      drv_events = (!drain && $urandom_range(3) == 0) ? (VEC_W'(1) << $urandom_range(VEC_W - 1)) : '0;
      if (drain) drv_mask = '0;
      else if ($urandom_range(15) == 0) drv_mask = VEC_W'($urandom) & VEC_W'($urandom);
      enable     = drain ? 1'b1 : ($urandom_range(9) != 0);
      drv_ready  = drain ? 1'b1 : 1'($urandom_range(1));
      req_h1     = req_h0;
      req_h0     = enable & src_req;
      pend_pre   = src_status & ~drv_mask;
      ready_pre  = drv_ready;
    end
    check("rnd drained status", 32'(src_status), 32'd0);
    check("rnd drained busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dxm_int_servicer.md
DXM_INT_SERVICER -- requirements
Module: dxm_int_servicer

Interface
REQ-001 The block SHALL have parameter VEC_W, default 8: width of the interrupt status vector (2..32).
REQ-002 The block SHALL have parameter TO_CYC, default 16: service-timeout limit in cycles (1..255); used only when DXM_INT_SVC_TIMEOUT_EN is defined.
REQ-003 The block SHALL have port clk, input, 1: clock.
REQ-004 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 The block SHALL have port enable, input, 1: servicing enabled.
REQ-006 The block SHALL have port int_req, input, 1: registered interrupt request from the interrupt source.
REQ-007 The block SHALL have port status, input, VEC_W: registered status vector from the source.
REQ-008 The block SHALL have port mask, input, VEC_W: mask vector shared with the source; 1 = masked.
REQ-009 The block SHALL have port clr_status_1p, output, 1: one-cycle clear strobe to the source.
REQ-010 The block SHALL have port clr_vec, output, VEC_W: one-hot clear data to the source's r_din; zero when clr_status_1p is low.
REQ-011 The block SHALL have port svc_valid, output, 1: service request to the handler agent.
REQ-012 The block SHALL have port svc_idx, output, $clog2(VEC_W): index of the bit being serviced.
REQ-013 The block SHALL have port svc_ready, input, 1: handler acceptance.
REQ-014 The block SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 The block SHALL have port spur_cnt, output, 8: saturating count of spurious requests.
REQ-016 The block SHALL have port svc_timeout, output, 1: one-cycle timeout pulse (timeout build only).

Function
REQ-017 The FSM SHALL have exactly the states IDLE, SAMPLE, DISPATCH, CLEAR, SETTLE1 and SETTLE2.
REQ-018 In IDLE, if enable=1 and int_req=1 at a clock edge, the next state SHALL be SAMPLE; otherwise the FSM SHALL stay in IDLE.
REQ-019 In SAMPLE, pend = status & ~mask SHALL be computed; if pend is nonzero, the lowest set index SHALL be latched into svc_idx and the next state SHALL be DISPATCH.
REQ-020 In SAMPLE, if pend is zero, spur_cnt SHALL increment (saturating at 255) and the next state SHALL be IDLE.
REQ-021 svc_valid SHALL be high throughout DISPATCH, and svc_idx SHALL be stable while svc_valid is high.
REQ-022 DISPATCH SHALL exit to CLEAR at the first edge where svc_ready=1.
REQ-023 In CLEAR, clr_status_1p SHALL be 1 and clr_vec SHALL be 1<<svc_idx for exactly one cycle; the next state SHALL be SETTLE1.
REQ-024 SETTLE1 SHALL go to SETTLE2 and SETTLE2 SHALL go to IDLE unconditionally; this covers the source's 1-cycle status and 2-cycle int_req update latency.
REQ-025 Latency: svc_valid SHALL assert 2 cycles after int_req is sampled high in IDLE.
REQ-026 Latency: clr_status_1p SHALL assert 1 cycle after the svc_ready handshake.
REQ-027 A service pass SHALL take at least 6 cycles.
REQ-028 enable=0 outside IDLE SHALL NOT abort the current pass; the FSM SHALL then hold in IDLE.
REQ-029 Mask or status changes during DISPATCH SHALL NOT alter svc_idx.
REQ-030 A new event arriving on the already-serviced bit during CLEAR SHALL remain pending, because the source's events_1p has priority over the clear, and SHALL be serviced on a later pass.
REQ-031 Multiple pending bits SHALL be serviced one per pass in ascending index order.

Reset
REQ-032 On rst_n=0, the FSM SHALL immediately return to IDLE regardless of current state, including mid-DISPATCH.
REQ-033 On rst_n=0, svc_valid, clr_status_1p, busy and svc_timeout SHALL be 0, and clr_vec, svc_idx and spur_cnt SHALL be 0.
REQ-034 No clear strobe SHALL be emitted as a result of reset.

Configuration
REQ-035 When macro DXM_INT_SVC_TIMEOUT_EN is defined, an 8-bit counter SHALL count cycles in DISPATCH.
REQ-036 With DXM_INT_SVC_TIMEOUT_EN defined, if TO_CYC cycles elapse without svc_ready, svc_timeout SHALL pulse for 1 cycle and the FSM SHALL proceed to CLEAR (bit dropped); the counter SHALL be zeroed on DISPATCH entry.
REQ-037 Without DXM_INT_SVC_TIMEOUT_EN, no counter SHALL be built, svc_timeout SHALL be tied to 0, and DISPATCH SHALL wait indefinitely.

Verification
REQ-038 The bench SHALL check: VEC_W=8, status=0x04, mask=0x00, int_req=1, svc_ready=1 on the first svc_valid cycle -> svc_idx=2, then clr_vec=0x04 with clr_status_1p for 1 cycle, then IDLE after SETTLE2.
REQ-039 The bench SHALL check: status=0x28, mask=0x00 -> two passes, svc_idx=3 then svc_idx=5, with clr_vec 0x08 then 0x20.
REQ-040 The bench SHALL check: int_req=1, status=0x01, mask=0x01 -> no svc_valid, spur_cnt 0->1, FSM back in IDLE.
REQ-041 The bench SHALL check: svc_ready held low with DXM_INT_SVC_TIMEOUT_EN and TO_CYC=4 -> svc_timeout pulses after 4 DISPATCH cycles, then clr_status_1p; without the macro, svc_valid stays high for at least 100 cycles.
REQ-042 The bench SHALL check: rst_n low for 1 cycle during DISPATCH -> svc_valid=0 immediately, no clr_status_1p, and busy=0.
REQ-043 The bench SHALL check: 300 spurious requests -> spur_cnt saturates at 255.
